// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences core reset and run enable,
// counts run cycles and retired instructions, and stops on halt, PC self-loop or timeout.
module mips_run_ctrl #(
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 10,
    parameter int IDLE_LIMIT   = 4,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 instr_retired,
    input  logic                 halt_req,
    output logic                 core_reset,
    output logic                 core_run,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_cause,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [HW-1:0]         hold_cnt_r;
    logic [CNT_WIDTH-1:0]  same_cnt_r;
    logic [PC_WIDTH-1:0]   pc_prev_r;
    logic                  prev_valid_r;

    logic [CNT_WIDTH-1:0]  cyc_inc_s, ret_inc_s, same_inc_s;
    logic                  idle_fire_s, tout_fire_s;
    logic [1:0]            fire_cause_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    // Candidate counter values and termination conditions for the current RUN cycle
    always_comb begin
        cyc_inc_s  = sat_inc(cycle_count);
        ret_inc_s  = instr_retired ? sat_inc(retired_count) : retired_count;
        same_inc_s = (prev_valid_r && (pc == pc_prev_r)) ? sat_inc(same_cnt_r) : {CNT_WIDTH{1'b0}};
        // Zero-extended compare so a budget wider than the counter never matches by truncation
        idle_fire_s = (IDLE_LIMIT != 0) && (32'(same_inc_s) == IDLE_LIMIT);
        tout_fire_s = (MAX_CYCLES != 0) && (32'(cyc_inc_s) == MAX_CYCLES);
        if (halt_req) begin
            fire_cause_s = 2'd1;
        end else if (idle_fire_s) begin
            fire_cause_s = 2'd2;
        end else if (tout_fire_s) begin
            fire_cause_s = 2'd3;
        end else begin
            fire_cause_s = 2'd0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (fire_cause_s != 2'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs and run bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            core_reset    <= 1'b1;
            core_run      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            done_cause    <= 2'd0;
            cycle_count   <= {CNT_WIDTH{1'b0}};
            retired_count <= {CNT_WIDTH{1'b0}};
            hold_cnt_r    <= {HW{1'b0}};
            same_cnt_r    <= {CNT_WIDTH{1'b0}};
            pc_prev_r     <= {PC_WIDTH{1'b0}};
            prev_valid_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            core_reset <= (state_s == ST_IDLE) || (state_s == ST_HOLD);
            core_run   <= (state_s == ST_RUN);
            busy       <= (state_s == ST_HOLD) || (state_s == ST_RUN);
            done       <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done_cause    <= 2'd0;
                        cycle_count   <= {CNT_WIDTH{1'b0}};
                        retired_count <= {CNT_WIDTH{1'b0}};
                        hold_cnt_r    <= {HW{1'b0}};
                        same_cnt_r    <= {CNT_WIDTH{1'b0}};
                        prev_valid_r  <= 1'b0;
                    end else begin
                        hold_cnt_r    <= hold_cnt_r;
                    end
                end
                ST_HOLD: begin
                    hold_cnt_r <= hold_cnt_r + HW'(1);
                end
                ST_RUN: begin
                    cycle_count   <= cyc_inc_s;
                    retired_count <= ret_inc_s;
                    pc_prev_r     <= pc;
                    prev_valid_r  <= 1'b1;
                    same_cnt_r    <= same_inc_s;
                    if (fire_cause_s != 2'd0) begin
                        done_cause <= fire_cause_s;
                    end else begin
                        done_cause <= done_cause;
                    end
                end
                default: begin
                    hold_cnt_r <= {HW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: four parameterisations share one stimulus stream,
// each scenario task checks the instance whose parameters it exercises.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        instr_retired = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] pc_step = 32'd4;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic a_core_reset, a_core_run, a_busy, a_done;
    logic [1:0] a_cause;
    logic [15:0] a_cyc, a_ret;
    logic b_core_reset, b_core_run, b_busy, b_done;
    logic [1:0] b_cause;
    logic [15:0] b_cyc, b_ret;
    logic c_core_reset, c_core_run, c_busy, c_done;
    logic [1:0] c_cause;
    logic [15:0] c_cyc, c_ret;
    logic d_core_reset, d_core_run, d_busy, d_done;
    logic [1:0] d_cause;
    logic [3:0] d_cyc, d_ret;

    mips_run_ctrl u_a (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_retired(instr_retired),
        .halt_req(halt_req), .core_reset(a_core_reset), .core_run(a_core_run), .busy(a_busy),
        .done(a_done), .done_cause(a_cause), .cycle_count(a_cyc), .retired_count(a_ret));

    mips_run_ctrl #(.MAX_CYCLES(3)) u_b (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_retired(instr_retired),
        .halt_req(halt_req), .core_reset(b_core_reset), .core_run(b_core_run), .busy(b_busy),
        .done(b_done), .done_cause(b_cause), .cycle_count(b_cyc), .retired_count(b_ret));

    mips_run_ctrl #(.RESET_CYCLES(3)) u_c (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_retired(instr_retired),
        .halt_req(halt_req), .core_reset(c_core_reset), .core_run(c_core_run), .busy(c_busy),
        .done(c_done), .done_cause(c_cause), .cycle_count(c_cyc), .retired_count(c_ret));

    mips_run_ctrl #(.MAX_CYCLES(0), .IDLE_LIMIT(0), .CNT_WIDTH(4)) u_d (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_retired(instr_retired),
        .halt_req(halt_req), .core_reset(d_core_reset), .core_run(d_core_run), .busy(d_busy),
        .done(d_done), .done_cause(d_cause), .cycle_count(d_cyc), .retired_count(d_ret));

    task automatic tick;
        @(posedge clk);
        #1;
        pc = pc + pc_step;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        instr_retired = 1'b1;
        repeat (2) tick;
        reset = 1'b1;
        tick;
    endtask

    // Leaves the bench in cycle 1 (first cycle after the start edge)
    task automatic start_run;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick;
        checks++;
        if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got=%b exp=1000", {a_core_reset, a_core_run, a_busy, a_done});
        end
        checks++;
        if ({a_cause, a_cyc, a_ret} !== 34'd0) begin
            errors++; $display("FAIL reset_values got cause=%0d cyc=%0d ret=%0d exp all 0", a_cause, a_cyc, a_ret);
        end
        reset = 1'b1;
        repeat (2) tick;
        checks++;
        if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b1000) begin
            errors++; $display("FAIL idle_no_start got=%b exp=1000", {a_core_reset, a_core_run, a_busy, a_done});
        end
    endtask

    task automatic test_timeout;
        do_reset;
        pc = 32'd0; pc_step = 32'd4;
        start_run;
        checks++;
        if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b1010) begin
            errors++; $display("FAIL to_hold got=%b exp=1010", {a_core_reset, a_core_run, a_busy, a_done});
        end
        for (int c = 2; c <= 11; c++) begin
            tick;
            checks++;
            if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b0110 || a_cyc !== 16'(c - 2)) begin
                errors++; $display("FAIL to_run_c%0d got=%b cyc=%0d exp=0110 cyc=%0d",
                                   c, {a_core_reset, a_core_run, a_busy, a_done}, a_cyc, c - 2);
            end
        end
        tick;
        checks++;
        if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b0001 || a_cause !== 2'd3 ||
            a_cyc !== 16'd10 || a_ret !== 16'd10) begin
            errors++; $display("FAIL to_done got=%b cause=%0d cyc=%0d ret=%0d exp=0001 3 10 10",
                               {a_core_reset, a_core_run, a_busy, a_done}, a_cause, a_cyc, a_ret);
        end
        repeat (3) tick;
        checks++;
        if (a_done !== 1'b1 || a_cause !== 2'd3 || a_cyc !== 16'd10 || a_ret !== 16'd10) begin
            errors++; $display("FAIL to_frozen got done=%0d cause=%0d cyc=%0d ret=%0d exp 1 3 10 10",
                               a_done, a_cause, a_cyc, a_ret);
        end
    endtask

    task automatic test_halt;
        do_reset;
        pc = 32'd0; pc_step = 32'd4;
        start_run;
        tick;
        tick;
        instr_retired = 1'b0;
        tick;
        instr_retired = 1'b1;
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_cause !== 2'd1 || a_cyc !== 16'd3 || a_ret !== 16'd2) begin
            errors++; $display("FAIL halt got done=%0d cause=%0d cyc=%0d ret=%0d exp 1 1 3 2",
                               a_done, a_cause, a_cyc, a_ret);
        end
        checks++;
        if (b_done !== 1'b1 || b_cause !== 2'd1 || b_cyc !== 16'd3 || b_ret !== 16'd2) begin
            errors++; $display("FAIL halt_vs_timeout got done=%0d cause=%0d cyc=%0d ret=%0d exp 1 1 3 2",
                               b_done, b_cause, b_cyc, b_ret);
        end
        start_run;
        checks++;
        if ({a_core_reset, a_busy, a_done} !== 3'b110 || a_cause !== 2'd0 || a_cyc !== 16'd0 || a_ret !== 16'd0) begin
            errors++; $display("FAIL restart_from_done got=%b cause=%0d cyc=%0d ret=%0d exp=110 0 0 0",
                               {a_core_reset, a_busy, a_done}, a_cause, a_cyc, a_ret);
        end
    endtask

    task automatic test_idle;
        do_reset;
        pc = 32'h0000_0040; pc_step = 32'd0;
        start_run;
        for (int c = 2; c <= 6; c++) begin
            tick;
            checks++;
            if (a_done !== 1'b0) begin
                errors++; $display("FAIL idle_early_c%0d got done=%0d exp=0", c, a_done);
            end
        end
        tick;
        checks++;
        if (a_done !== 1'b1 || a_cause !== 2'd2 || a_cyc !== 16'd5) begin
            errors++; $display("FAIL idle got done=%0d cause=%0d cyc=%0d exp 1 2 5", a_done, a_cause, a_cyc);
        end
        do_reset;
        pc = 32'h0000_0040; pc_step = 32'd0;
        start_run;
        repeat (4) tick;
        pc = 32'h0000_0044;
        repeat (4) tick;
        checks++;
        if (a_done !== 1'b0 || a_cyc !== 16'd7) begin
            errors++; $display("FAIL idle_delayed_early got done=%0d cyc=%0d exp 0 7", a_done, a_cyc);
        end
        tick;
        checks++;
        if (a_done !== 1'b1 || a_cause !== 2'd2 || a_cyc !== 16'd8) begin
            errors++; $display("FAIL idle_delayed got done=%0d cause=%0d cyc=%0d exp 1 2 8", a_done, a_cause, a_cyc);
        end
    endtask

    task automatic test_reset_hold;
        do_reset;
        pc = 32'd0; pc_step = 32'd4;
        start_run;
        checks++;
        if ({c_core_reset, c_core_run, c_busy} !== 3'b101) begin
            errors++; $display("FAIL hold_c1 got=%b exp=101", {c_core_reset, c_core_run, c_busy});
        end
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({c_core_reset, c_core_run, c_busy} !== 3'b101) begin
            errors++; $display("FAIL hold_c3 got=%b exp=101", {c_core_reset, c_core_run, c_busy});
        end
        tick;
        checks++;
        if ({c_core_reset, c_core_run, c_busy} !== 3'b011) begin
            errors++; $display("FAIL hold_run_c4 got=%b exp=011", {c_core_reset, c_core_run, c_busy});
        end
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({c_core_reset, c_core_run, c_busy} !== 3'b011 || c_cyc !== 16'd2) begin
            errors++; $display("FAIL start_in_run got=%b cyc=%0d exp=011 2", {c_core_reset, c_core_run, c_busy}, c_cyc);
        end
    endtask

    task automatic test_abort;
        do_reset;
        pc = 32'd0; pc_step = 32'd4;
        start_run;
        repeat (4) tick;
        reset = 1'b0;
        #1;
        checks++;
        if ({a_core_reset, a_core_run, a_busy, a_done} !== 4'b1000 || a_cause !== 2'd0 ||
            a_cyc !== 16'd0 || a_ret !== 16'd0) begin
            errors++; $display("FAIL abort got=%b cause=%0d cyc=%0d ret=%0d exp=1000 0 0 0",
                               {a_core_reset, a_core_run, a_busy, a_done}, a_cause, a_cyc, a_ret);
        end
        #2;
        reset = 1'b1;
        tick;
        start_run;
        repeat (11) tick;
        checks++;
        if (a_done !== 1'b1 || a_cause !== 2'd3 || a_cyc !== 16'd10 || a_ret !== 16'd10) begin
            errors++; $display("FAIL abort_rerun got done=%0d cause=%0d cyc=%0d ret=%0d exp 1 3 10 10",
                               a_done, a_cause, a_cyc, a_ret);
        end
    endtask

    task automatic test_saturate;
        do_reset;
        pc = 32'h0000_0100; pc_step = 32'd0;
        start_run;
        repeat (9) tick;
        checks++;
        if (d_cyc !== 4'd8 || d_busy !== 1'b1) begin
            errors++; $display("FAIL sat_mid got cyc=%0d busy=%0d exp 8 1", d_cyc, d_busy);
        end
        repeat (11) tick;
        checks++;
        if (d_cyc !== 4'd15 || d_busy !== 1'b1 || d_done !== 1'b0) begin
            errors++; $display("FAIL sat_hold got cyc=%0d busy=%0d done=%0d exp 15 1 0", d_cyc, d_busy, d_done);
        end
        repeat (5) tick;
        checks++;
        if (d_cyc !== 4'd15 || d_ret !== 4'd15 || d_done !== 1'b0) begin
            errors++; $display("FAIL sat_stay got cyc=%0d ret=%0d done=%0d exp 15 15 0", d_cyc, d_ret, d_done);
        end
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        checks++;
        if (d_done !== 1'b1 || d_cause !== 2'd1 || d_cyc !== 4'd15) begin
            errors++; $display("FAIL sat_halt got done=%0d cause=%0d cyc=%0d exp 1 1 15", d_done, d_cause, d_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_timeout;
        test_halt;
        test_idle;
        test_reset_hold;
        test_abort;
        test_saturate;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
